// File: rtl/mux_pkg.sv
// mux_pkg: select encodings and default width shared by the mux tree
package mux_pkg;
  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b10;
  localparam logic [1:0] SEL_D3 = 2'b11;
  localparam int DEF_DATA_WIDTH = 1;
endpackage

// File: rtl/mux_2to1.sv
// mux_2to1: plain 2:1 leaf of the 4:1 tree, i_sel=1 picks i_b
module mux_2to1 import mux_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_sel,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/mux_4to1.sv
// mux_4to1: 4:1 mux tree with X-safe select and optional reset-gated output register
module mux_4to1 import mux_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit REG_OUT    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0,
  input  logic                  s1,
  input  logic [DATA_WIDTH-1:0] d0,
  input  logic [DATA_WIDTH-1:0] d1,
  input  logic [DATA_WIDTH-1:0] d2,
  input  logic [DATA_WIDTH-1:0] d3,
  output logic [DATA_WIDTH-1:0] y
);
  logic [DATA_WIDTH-1:0] w_lo, w_hi, w_tree, w_nxt;
  mux_2to1 #(.DATA_WIDTH(DATA_WIDTH)) u_lo (.i_sel(s0), .i_a(d0),   .i_b(d1),   .o_y(w_lo));
  mux_2to1 #(.DATA_WIDTH(DATA_WIDTH)) u_hi (.i_sel(s0), .i_a(d2),   .i_b(d3),   .o_y(w_hi));
  mux_2to1 #(.DATA_WIDTH(DATA_WIDTH)) u_st (.i_sel(s1), .i_a(w_lo), .i_b(w_hi), .o_y(w_tree));
  // unknown select yields zero so simulation never propagates X
  always_comb w_nxt = $isunknown({s1, s0}) ? '0 : w_tree;
  generate
    if (REG_OUT) begin : g_reg
      logic [DATA_WIDTH-1:0] r_y;
      // retime the selection, clearing on active-low reset
      always_ff @(posedge clk) r_y <= !rst ? '0 : w_nxt;
      assign y = r_y;
    end else begin : g_comb
      assign y = rst ? w_nxt : '0;
    end
  endgenerate
endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: scoreboard bench for registered (1b, 8b) and combinational (4b) variants
module tb_mux_4to1;
  import mux_pkg::*;
  typedef struct {
    bit         c1;
    logic       e1;
    bit         c8;
    logic [7:0] e8;
    string      nm;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s0 = 1'b0, s1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic       y1;
  logic [7:0] y8;
  logic [3:0] y4;
  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  mux_4to1 #(.DATA_WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1),
    .d0(d0[0]), .d1(d1[0]), .d2(d2[0]), .d3(d3[0]), .y(y1));
  mux_4to1 #(.DATA_WIDTH(8), .REG_OUT(1'b1)) u8 (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .y(y8));
  mux_4to1 #(.DATA_WIDTH(4), .REG_OUT(1'b0)) u4 (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1),
    .d0(d0[3:0]), .d1(d1[3:0]), .d2(d2[3:0]), .d3(d3[3:0]), .y(y4));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // drive one vector between edges and queue the response due after the next edge
  task automatic step(input logic [1:0] sel, input logic [7:0] a, b, c, e, input logic rr,
                      input bit c1, input logic e1, input bit c8, input logic [7:0] e8,
                      input string nm);
    exp_t x;
    @(negedge clk);
    #1;
    {s1, s0} = sel;
    d0 = a; d1 = b; d2 = c; d3 = e;
    rst = rr;
    x.c1 = c1; x.e1 = e1; x.c8 = c8; x.e8 = e8; x.nm = nm;
    q.push_back(x);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      if (x.c1) chk({x.nm, "_y1"}, {7'b0, y1}, {7'b0, x.e1});
      if (x.c8) chk({x.nm, "_y8"}, y8, x.e8);
    end
  end
  initial begin
    logic [5:0] v;
    for (int i = 0; i < 3; i++)
      step(SEL_D3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1, 1'b0, 1, 8'h00, "reset_hold");
    step(SEL_D3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1, 1'b1, 1, 8'hFF, "reset_release");
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      step(v[5:4], {7'b0, v[0]}, {7'b0, v[1]}, {7'b0, v[2]}, {7'b0, v[3]}, 1'b1,
           1, v[v[5:4]], 1, {7'b0, v[v[5:4]]}, "sweep");
    end
    step(SEL_D0, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1, 8'hA5, "lat_sel0");
    step(SEL_D1, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1, 8'h3C, "lat_sel1");
    #2;
    chk("lat_no_glitch", y8, 8'hA5);
    step(SEL_D2, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 1, 1'b1, 1, 8'hFF, "midrst_run");
    step(SEL_D2, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1, 1'b0, 1, 8'h00, "midrst_hit");
    step(SEL_D2, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 1, 1'b1, 1, 8'hFF, "midrst_rel");
    step(2'b0x, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1, 1'b0, 1, 8'h00, "xsel");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    {s1, s0} = SEL_D3; d3 = 8'h09; rst = 1'b1;
    #1;
    chk("comb_sel3", {4'b0, y4}, 8'h09);
    rst = 1'b0;
    #1;
    chk("comb_rst", {4'b0, y4}, 8'h00);
    {s1, s0} = SEL_D1; d1 = 8'h06; rst = 1'b1;
    #1;
    chk("comb_sel1", {4'b0, y4}, 8'h06);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
